// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw mechanical push-button / switch level into a clean, glitch-free
// level and produces single-cycle rise/fall strobes. The raw input passes
// through an internal 2-flop synchronizer, so a pad signal may be connected
// directly. A new level is accepted only after N_STABLE+1 consecutive
// synchronized samples at that level; any bounce restarts qualification.
//
// Optional feature (compile-time macro DEBOUNCE_LONGPRESS_EN):
//   when defined, long_press strobes once after `out` has been high for
//   N_LONG cycles; a release and re-press re-arms it. When undefined,
//   long_press is tied to 0 and the long-hold counter does not exist.
//
// Parameters:
//   N_STABLE : qualification length in samples (>= 2)
//   N_LONG   : long-hold length in cycles (optional feature only)
//   CNT_W    : counter width, must hold max(N_STABLE, N_LONG)-1
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   inp        : raw asynchronous button level
//   out        : debounced level
//   rise       : one-cycle strobe coincident with out going 0->1
//   fall       : one-cycle strobe coincident with out going 1->0
//   long_press : one-cycle strobe on a long hold (0 when feature disabled)
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int N_STABLE = 1250000,
  parameter int N_LONG   = 125000000,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic inp,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long_press
);

  if (N_STABLE < 2 || N_LONG < 1 || CNT_W < 1) begin : g_param_check
    $error("button_debouncer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(N_STABLE - 1);

  logic             q1_p0;
  logic             q2_p1;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             out_nxt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous pad level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1_p0 <= 1'b0;
      q2_p1 <= 1'b0;
    end else begin
      q1_p0 <= inp;
      q2_p1 <= q1_p0;
    end
  end

  // Stage p2: qualification FSM, sees only the synchronized level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (q2_p1) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        // A single low sample throws away all progress: no partial credit.
        if (!q2_p1) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!q2_p1) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (q2_p1) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
    // The debounced level is high while a high level is held or being
    // re-qualified low; it is registered so it cannot glitch on decode.
    out_nxt = (state_nxt == IDLE_HIGH) || (state_nxt == WAIT_LOW);
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(N_LONG - 1);

  logic [CNT_W-1:0] lcnt;
  logic             lfired;

  // Stage p3: long-hold counter; saturates once fired so it never repeats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt       <= '0;
      lfired     <= 1'b0;
      long_press <= 1'b0;
    end else if (!out) begin
      lcnt       <= '0;
      lfired     <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= (lcnt == LONG_LAST) && !lfired;
      if (lcnt == LONG_LAST) begin
        lfired <= 1'b1;
      end else begin
        lcnt <= lcnt + CNT_ONE;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Bench for button_debouncer with N_STABLE=4, N_LONG=10. A behavioural model
// states the rules directly: the synchronized input is the raw input delayed
// by two edges; the debounced level flips once N_STABLE+1 consecutive samples
// disagree with it; long_press fires on the edge after `out` has been high
// for N_LONG consecutive cycles. A compare process checks every cycle, and
// directed scenarios pin exact latencies with literal expectations.
// long_press expectations follow DEBOUNCE_LONGPRESS_EN.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int NS = 4;
  localparam int NL = 10;
  localparam int CW = 8;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int LP_ON = 1;
`else
  localparam int LP_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inp = 1'b0;
  logic out, rise, fall, long_press;

  int total = 0;
  int bad   = 0;
  int n_rise = 0, n_fall = 0, n_lp = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(.N_STABLE(NS), .N_LONG(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .out(out), .rise(rise), .fall(fall), .long_press(long_press)
  );

  // Reference model
  logic m_d1, m_d2, m_out, m_rise, m_fall, m_lp;
  int   m_run;  // consecutive samples disagreeing with m_out
  int   m_hi;   // consecutive cycles m_out has been high (capped)
  wire  m_flip = (m_d2 != m_out) && (m_run == NS);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_out <= 1'b0;
      m_rise <= 1'b0; m_fall <= 1'b0; m_lp <= 1'b0;
      m_run <= 0; m_hi <= 0;
    end else begin
      m_d1 <= inp;
      m_d2 <= m_d1;
      m_out  <= m_out ^ m_flip;
      m_rise <= m_flip && !m_out;
      m_fall <= m_flip && m_out;
      m_run  <= m_flip ? 0 : ((m_d2 != m_out) ? m_run + 1 : 0);
      m_lp   <= m_out && (m_hi == NL);
      m_hi   <= (m_out ^ m_flip) ? ((m_hi > NL) ? m_hi : m_hi + 1) : 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("cyc_out",  int'(out),  int'(m_out));
      chk("cyc_rise", int'(rise), int'(m_rise));
      chk("cyc_fall", int'(fall), int'(m_fall));
      chk("cyc_long", int'(long_press), LP_ON ? int'(m_lp) : 0);
      if (rise) n_rise++;
      if (fall) n_fall++;
      if (long_press) n_lp++;
    end
  end

  task automatic wn(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Input already changed at the current negedge: level must appear after
  // edge 6 with its strobe for exactly that cycle.
  task automatic qual_check(input string nm, input bit level);
    wn(6);
    chk({nm, "_before"}, int'(out), int'(!level));
    wn(1);
    chk({nm, "_after"}, int'(out), int'(level));
    chk({nm, "_strobe"}, int'(level ? rise : fall), 1);
    chk({nm, "_other"}, int'(level ? fall : rise), 0);
    wn(1);
    chk({nm, "_strobe_end"}, int'(level ? rise : fall), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r0, f0, l0, hold;

    // Reset held with inp high
    inp = 1'b1;
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    wn(3);
    chk("rst_out",  int'(out),  0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_long", int'(long_press), 0);
    rst = 1'b1;
    qual_check("rst_release", 1'b1);
    wn(3);

    // Clean release then clean press
    inp = 1'b0;
    qual_check("release", 1'b0);
    wn(4);
    inp = 1'b1;
    qual_check("press", 1'b1);
    wn(3);
    inp = 1'b0;
    wn(12);

    // 4-cycle glitch rejected
    r0 = n_rise;
    inp = 1'b1; wn(4); inp = 1'b0; wn(12);
    chk("glitch4_rises", n_rise - r0, 0);
    chk("glitch4_out", int'(out), 0);

    // 5-cycle pulse accepted, then falls again
    r0 = n_rise; f0 = n_fall;
    inp = 1'b1; wn(5); inp = 1'b0; wn(20);
    chk("pulse5_rises", n_rise - r0, 1);
    chk("pulse5_falls", n_fall - f0, 1);
    chk("pulse5_out", int'(out), 0);

    // Bounce 1,0,1,0 then hold 1
    r0 = n_rise;
    inp = 1'b1; wn(1); inp = 1'b0; wn(1);
    inp = 1'b1; wn(1); inp = 1'b0; wn(1);
    inp = 1'b1;
    qual_check("bounce", 1'b1);
    chk("bounce_rises", n_rise - r0, 1);
    inp = 1'b0;
    wn(12);

    // Reset two cycles into a press, released with inp still high
    inp = 1'b1; wn(2);
    r0 = n_rise; f0 = n_fall;
    rst = 1'b0;
    wn(3);
    chk("rstmid_out", int'(out), 0);
    chk("rstmid_rises", n_rise - r0, 0);
    chk("rstmid_falls", n_fall - f0, 0);
    l0 = n_lp;
    rst = 1'b1;
    qual_check("rstmid", 1'b1);

    // Long hold: long_press lands 10 cycles after out rose
    wn(8);
    chk("long_early", int'(long_press), 0);
    wn(1);
    chk("long_fire", int'(long_press), LP_ON);
    wn(1);
    chk("long_end", int'(long_press), 0);
    wn(14);
    chk("long_count1", n_lp - l0, LP_ON);
    inp = 1'b0; wn(12);
    inp = 1'b1; wn(30);
    inp = 1'b0; wn(12);
    chk("long_count2", n_lp - l0, 2 * LP_ON);

    // Randomized stimulus around the qualification boundary
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        inp = 1'($urandom_range(0, 1));
        wn($urandom_range(1, 3));
        rst = 1'b1;
      end else begin
        inp = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30)
                                           : $urandom_range(1, 7);
        wn(hold);
      end
    end
    inp = 1'b0;
    wn(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
